// File: rtl/byte_mem_hs.sv
// byte_mem_hs: big-endian byte memory with MOV/MOC handshake, latency, sized access and error flag
module byte_mem_hs #(
  parameter int    ADDR_W    = 9,
  parameter int    DEPTH     = 512,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "testcode.txt"
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mov,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] idx [4];
  logic [7:0]        rb [4];
  logic [7:0]        wb [4];
  logic [3:0]        we;
  logic [31:0]       ld;
  logic              accept, fire, bad, leave;

  function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W-1:0] a, input int k);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + (ADDR_W+1)'(k);
    return (s >= DEPTH_W) ? ADDR_W'(s - DEPTH_W) : ADDR_W'(s);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) & mov;
    fire    = (state_q == WAIT) & (cnt_q == 4'd0);
    leave   = (state_q == DONE) & ~mov;
    state_d = accept ? WAIT : fire ? DONE : leave ? IDLE : state_q;
    cnt_d   = accept ? 4'(LATENCY - 1) : ((state_q == WAIT) & (cnt_q != 4'd0)) ? cnt_q - 4'd1 : cnt_q;
    addr_d  = accept ? address   : addr_q;
    size_d  = accept ? size      : size_q;
    sext_d  = accept ? sign_ext  : sext_q;
    rd_d    = accept ? mem_read  : rd_q;
    wr_d    = accept ? mem_write : wr_q;
    din_d   = accept ? data_in   : din_q;
  end

  always_comb begin
    bad = (rd_q == wr_q) | (size_q == 2'b11) | ((size_q == 2'b01) & addr_q[0])
        | ((size_q == 2'b10) & (|addr_q[1:0])) | ({1'b0, addr_q} >= DEPTH_W);
    for (int k = 0; k < 4; k++) begin
      idx[k] = wrap(addr_q, k);
      rb[k]  = mem[idx[k]];
    end
    ld = (size_q == 2'b00) ? {{24{sext_q & rb[0][7]}}, rb[0]}
       : (size_q == 2'b01) ? {{16{sext_q & rb[0][7]}}, rb[0], rb[1]}
       : {rb[0], rb[1], rb[2], rb[3]};
    we = ~(fire & wr_q & ~bad) ? 4'b0000
       : (size_q == 2'b00) ? 4'b0001 : (size_q == 2'b01) ? 4'b0011 : 4'b1111;
    wb[0] = (size_q == 2'b00) ? din_q[7:0] : (size_q == 2'b01) ? din_q[15:8] : din_q[31:24];
    wb[1] = (size_q == 2'b01) ? din_q[7:0] : din_q[23:16];
    wb[2] = din_q[15:8];
    wb[3] = din_q[7:0];
    dout_d = (fire & rd_q & ~bad) ? ld : dout_q;
    err_d  = fire ? bad : leave ? 1'b0 : err_q;
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++)
      if (we[k]) mem[idx[k]] <= wb[k];
  end

  assign data_out = dout_q;
  assign moc      = (state_q == DONE);
  assign err      = err_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_byte_mem_hs.sv
// tb_byte_mem_hs: randomized scoreboard bench for byte_mem_hs against a byte-array
// reference model; a monitor pops expectations at every rising moc.
module tb_byte_mem_hs;
    localparam int AW = 9, DEPTH = 512, LAT = 2;

    logic          clock = 1'b0, reset = 1'b1, mov = 1'b0;
    logic          mem_read = 1'b0, mem_write = 1'b0, sign_ext = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] address = '0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          moc, err, busy;

    byte_mem_hs #(.ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clock(clock), .reset(reset), .mov(mov), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .sign_ext(sign_ext), .address(address), .data_in(data_in),
        .data_out(data_out), .moc(moc), .err(err), .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    byte unsigned ref_mem[DEPTH];
    logic [31:0] last_dout = '0;
    int          checks = 0, errors = 0;
    logic        mon_prev = 1'b0;
    exp_t        mon_x;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory as a byte array, values assembled with plain arithmetic.
    task automatic model(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                         input int a, input logic [31:0] din,
                         output logic [31:0] d, output logic e);
        int     n;
        longint v;
        n = 1 << sz;
        v = 0;
        e = (rd == wr) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a >= DEPTH;
        if (!e && rd) begin
            for (int k = 0; k < n; k++) v = v * 256 + longint'(ref_mem[(a + k) % DEPTH]);
            if (sx && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
            last_dout = 32'(v);
        end
        if (!e && wr)
            for (int k = 0; k < n; k++) ref_mem[(a + k) % DEPTH] = 8'(din >> (8 * (n - 1 - k)));
        d = last_dout;
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                      input int a, input logic [31:0] din, input int hold);
        exp_t x;
        int   w;
        @(negedge clock);
        mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
        address = AW'(a); data_in = din; mov = 1'b1;
        model(rd, wr, sz, sx, a, din, x.d, x.e);
        x.issue = cyc;
        sb.push_back(x);
        @(negedge clock);
        chk("busy_wait", 32'(busy), 32'd1);
        mem_read = 1'($urandom); mem_write = 1'($urandom); size = 2'($urandom);
        sign_ext = 1'($urandom); address = AW'($urandom); data_in = $urandom;
        w = 0;
        while (!moc && w < 40) begin
            @(negedge clock);
            w++;
        end
        chk("moc_seen", 32'(moc), 32'd1);
        repeat (hold) begin
            @(negedge clock);
            chk("moc_hold", 32'(moc), 32'd1);
        end
        mov = 1'b0;
        @(negedge clock);
        chk("moc_drop", 32'(moc), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial forever begin
        @(negedge clock);
        if (moc && !mon_prev) begin
            if (sb.size() == 0) chk("spurious_moc", 32'(moc), 32'd0);
            else begin
                mon_x = sb.pop_front();
                chk("data_out", data_out, mon_x.d);
                chk("err", 32'(err), 32'(mon_x.e));
                chk("latency", 32'(cyc - mon_x.issue), 32'(LAT + 1));
            end
        end
        mon_prev = moc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r;
        logic rd, wr;
        logic [1:0] sz;
        repeat (3) @(negedge clock);
        chk("reset_moc", 32'(moc), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dout", data_out, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i += 4) op(1'b0, 1'b1, 2'd2, 1'b0, i, $urandom, 0);

        op(1'b0, 1'b1, 2'd2, 1'b0, 0, 32'h2401002C, 0);
        op(1'b1, 1'b0, 2'd2, 1'b0, 0, 32'h0, 0);
        chk("t1_word", data_out, 32'h2401002C);

        op(1'b0, 1'b1, 2'd2, 1'b0, 8, 32'hDEADBEEF, 0);
        op(1'b1, 1'b0, 2'd0, 1'b1, 9, 32'h0, 0);
        chk("t2_signed", data_out, 32'hFFFFFFAD);
        op(1'b1, 1'b0, 2'd0, 1'b0, 9, 32'h0, 0);
        chk("t2_unsigned", data_out, 32'h000000AD);

        op(1'b0, 1'b1, 2'd2, 1'b0, 16, 32'h11223344, 0);
        op(1'b0, 1'b1, 2'd1, 1'b0, 16, 32'h00008001, 0);
        op(1'b1, 1'b0, 2'd2, 1'b0, 16, 32'h0, 0);
        chk("t3_half", data_out, 32'h80013344);

        op(1'b1, 1'b0, 2'd2, 1'b0, 6, 32'h0, 0);
        chk("t4_misalign_dout", data_out, 32'h80013344);
        op(1'b1, 1'b1, 2'd2, 1'b0, 16, 32'hFFFFFFFF, 0);
        chk("t4_rdwr_dout", data_out, 32'h80013344);
        op(1'b1, 1'b0, 2'd2, 1'b0, 16, 32'h0, 0);
        chk("t4_mem_kept", data_out, 32'h80013344);

        op(1'b0, 1'b1, 2'd0, 1'b0, 511, 32'h0000005A, 0);
        op(1'b1, 1'b0, 2'd0, 1'b0, 511, 32'h0, 5);
        chk("t5_top_byte", data_out, 32'h0000005A);

        op(1'b0, 1'b1, 2'd2, 1'b0, 32, 32'hCAFEF00D, 0);
        @(negedge clock);
        mem_read = 1'b0; mem_write = 1'b1; size = 2'd2; address = AW'(32);
        data_in = 32'h12345678; mov = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        mov = 1'b0;
        @(negedge clock);
        chk("t6_rst_moc", 32'(moc), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_dout", data_out, 32'd0);
        reset = 1'b0;
        last_dout = '0;
        repeat (3) begin
            @(negedge clock);
            chk("t6_no_moc", 32'(moc), 32'd0);
        end
        op(1'b1, 1'b0, 2'd2, 1'b0, 32, 32'h0, 0);
        chk("t6_old_value", data_out, 32'hCAFEF00D);

        repeat (300) begin
            r = $urandom_range(0, 9);
            rd = (r < 4) || (r == 8);
            wr = (r >= 4 && r < 8) || (r == 8);
            sz = 2'($urandom);
            a = $urandom_range(0, DEPTH - 1);
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            op(rd, wr, sz, 1'($urandom), a, $urandom, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
